// File: rtl/sram_bus_pkg.sv
// sram_bus_pkg: shared constants and types for the SRAM / I-O access sequencer.
// State codes, default I/O word address and the active-low strobe bundle.
package sram_bus_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] ACCESS = 3'd2;
    localparam logic [2:0] DONE   = 3'd3;
    localparam logic [2:0] IO     = 3'd4;

    localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;

    typedef struct packed {
        logic ce;
        logic ub;
        logic lb;
        logic oe;
        logic we;
    } strobe_t;

    localparam strobe_t STB_OFF = '{
        ce: 1'b1, ub: 1'b1, lb: 1'b1, oe: 1'b1, we: 1'b1
    };

endpackage

// File: rtl/bus_tristate.sv
// bus_tristate: the single driver of the shared 16-bit Data bus.
// Drives dout when out_en is set, otherwise releases the bus; din always mirrors it.
module bus_tristate (
    input  logic        out_en,
    input  logic [15:0] dout,
    inout  wire  [15:0] Data,
    output logic [15:0] din
);

    assign Data = out_en ? dout : 16'bz;
    assign din  = Data;

endmodule

// File: rtl/sram_bus_ctrl.sv
// sram_bus_ctrl: one-word-at-a-time sequencer for the async SRAM and the
// memory-mapped I/O word; generates strobes with WAIT_CYCLES wait states.
module sram_bus_ctrl
    import sram_bus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    input  logic [15:0] S,
    output logic [15:0] hex_out,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic [19:0] ADDR,
    inout  wire  [15:0] Data
);

    localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

    logic [2:0]  state;
    logic [2:0]  cnt;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic [15:0] hex_q;
    logic [15:0] din;
    logic        drive;
    strobe_t     stb;
    logic        accept;

    assign accept = req_valid && (state == IDLE);

    // Sequencer: IDLE -> SETUP -> ACCESS x WAIT_CYCLES -> DONE, or IDLE -> IO.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state <= (req_addr == IO_ADDR) ? IO : SETUP;
                        cnt   <= WAIT_LD;
                    end
                end
                SETUP:  state <= ACCESS;
                ACCESS: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                IO:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the request on accept; ADDR keeps this value afterwards.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Read data: SRAM sampled at the end of the last ACCESS cycle,
    // switches sampled at the end of the IO cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rdata_q <= 16'h0000;
        end else if (state == ACCESS && cnt == 3'd1 && !we_q) begin
            rdata_q <= din;
        end else if (state == IO && !we_q) begin
            rdata_q <= S;
        end
    end

    // Display register, loaded by a write to the I/O word.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            hex_q <= 16'h0000;
        else if (state == IO && we_q)
            hex_q <= wdata_q;
    end

    // Strobes and bus drive decoded from state; OE and drive are exclusive.
    always_comb begin
        stb   = STB_OFF;
        drive = 1'b0;
        case (state)
            SETUP: begin
                stb.ce = 1'b0;
                stb.ub = 1'b0;
                stb.lb = 1'b0;
                drive  = we_q;
            end
            ACCESS: begin
                stb.ce = 1'b0;
                stb.ub = 1'b0;
                stb.lb = 1'b0;
                stb.oe = we_q;
                stb.we = !we_q;
                drive  = we_q;
            end
            DONE: begin
                stb.ce = 1'b0;
                stb.ub = 1'b0;
                stb.lb = 1'b0;
                drive  = we_q;
            end
            default: begin
                stb   = STB_OFF;
                drive = 1'b0;
            end
        endcase
    end

    assign CE = stb.ce;
    assign UB = stb.ub;
    assign LB = stb.lb;
    assign OE = stb.oe;
    assign WE = stb.we;

    assign ADDR      = {4'b0000, addr_q};
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE) || (state == IO);
    assign rsp_rdata = (state == IO && !we_q) ? S : rdata_q;
    assign hex_out   = hex_q;

    bus_tristate u_tri (
        .out_en (drive),
        .dout   (wdata_q),
        .Data   (Data),
        .din    (din)
    );

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// tb_sram_bus_ctrl: directed stimulus, cycle-level access model and a fake
// async SRAM device on the shared Data bus.
module tb_sram_bus_ctrl;

    localparam int W = 2;
    localparam logic [15:0] IOA  = 16'hFFFF;
    localparam logic [15:0] PULL = 16'h5A5A;

    logic        Clk;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [15:0] S;
    logic [15:0] hex_out;
    logic        CE, UB, LB, OE, WE;
    logic [19:0] ADDR;
    wire  [15:0] Data;

    int checks   = 0;
    int failures = 0;

    sram_bus_ctrl #(
        .WAIT_CYCLES (W),
        .IO_ADDR     (IOA)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .S         (S),
        .hex_out   (hex_out),
        .CE        (CE),
        .UB        (UB),
        .LB        (LB),
        .OE        (OE),
        .WE        (WE),
        .ADDR      (ADDR),
        .Data      (Data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // ---------------- access model ----------------
    // ph = cycles since accept (0 = idle).
    int          ph = 0;
    logic        m_we = 1'b0;
    logic        m_io = 1'b0;
    logic [15:0] m_addr = 16'h0;
    logic [15:0] m_wdata = 16'h0;
    logic [15:0] exp_rdata = 16'h0;
    logic [15:0] exp_hex = 16'h0;
    logic [19:0] exp_addr = 20'h0;
    logic [15:0] mem_m [logic [15:0]];
    int          cyc = 0;
    int          acc_t[$];

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ph        = 0;
            exp_rdata = 16'h0;
            exp_hex   = 16'h0;
            exp_addr  = 20'h0;
        end else begin
            cyc++;
            if (ph == 0) begin
                if (req_valid) begin
                    m_we     = req_we;
                    m_addr   = req_addr;
                    m_wdata  = req_wdata;
                    m_io     = (req_addr == IOA);
                    exp_addr = {4'h0, req_addr};
                    acc_t.push_back(cyc);
                    ph = 1;
                end
            end else if (m_io) begin
                if (m_we) exp_hex = m_wdata;
                else      exp_rdata = S;
                ph = 0;
            end else begin
                if (ph == W + 1 && !m_we)
                    exp_rdata = mem_m[m_addr];
                if (ph == W + 2) begin
                    if (m_we) mem_m[m_addr] = m_wdata;
                    ph = 0;
                end else begin
                    ph++;
                end
            end
        end
    end

    logic m_drive;
    logic m_rdph;
    always_comb begin
        m_drive = 1'b0;
        m_rdph  = 1'b0;
        if (ph != 0 && !m_io) begin
            m_drive = m_we;
            m_rdph  = !m_we && ph >= 2 && ph <= W + 1;
        end
    end

    // ---------------- fake SRAM device + bus pull ----------------
    logic [15:0] sram [0:255];
    logic        bench_en;
    logic [15:0] bench_val;

    always_comb begin
        bench_en  = 1'b1;
        bench_val = PULL;
        if (!CE && !OE)
            bench_val = sram[ADDR[7:0]];
        else if (m_drive)
            bench_en = 1'b0;
    end

    assign Data = bench_en ? bench_val : 16'bz;

    always @(negedge Clk) begin
        if (!CE && !WE)
            sram[ADDR[7:0]] = Data;
    end

    // ---------------- per-cycle compare ----------------
    always begin
        @(posedge Clk);
        #4;
        begin
            logic        sa;
            logic        e_oe, e_we, e_val;
            logic [15:0] e_rd, e_dat;
            sa    = (ph != 0) && !m_io;
            e_oe  = !(sa && !m_we && ph >= 2 && ph <= W + 1);
            e_we  = !(sa && m_we && ph >= 2 && ph <= W + 1);
            e_val = (ph != 0) &&
                    ((m_io && ph == 1) || (!m_io && ph == W + 2));
            e_rd  = (ph == 1 && m_io && !m_we) ? S : exp_rdata;
            if (m_drive)     e_dat = m_wdata;
            else if (m_rdph) e_dat = mem_m[m_addr];
            else             e_dat = PULL;
            chk("ce", CE, !sa);
            chk("ub", UB, !sa);
            chk("lb", LB, !sa);
            chk("oe", OE, e_oe);
            chk("we", WE, e_we);
            chk("ready", req_ready, ph == 0);
            chk("valid", rsp_valid, e_val);
            chk("rdata", rsp_rdata, e_rd);
            chk("addr", ADDR, exp_addr);
            chk("hex", hex_out, exp_hex);
            chk("data", Data, e_dat);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_req(input logic we, input logic [15:0] a,
                          input logic [15:0] d, output int lat,
                          output int we_lo, output int oe_lo);
        @(negedge Clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(negedge Clk);
        req_valid = 1'b0;
        lat   = 0;
        we_lo = 0;
        oe_lo = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge Clk);
            if (!WE) we_lo++;
            if (!OE) oe_lo++;
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wl, ol, nv, base, t;
        for (int i = 0; i < 256; i++) sram[i] = 16'h0000;
        sram[8'h20]     = 16'hC0DE;
        mem_m[16'h0020] = 16'hC0DE;

        Reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 16'h0;
        req_wdata = 16'h0;
        S         = 16'h0;
        repeat (3) @(negedge Clk);
        chk("rst_strobes", {CE, UB, LB, OE, WE}, 5'h1F);
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 16'h0);
        chk("rst_hex", hex_out, 16'h0);
        chk("rst_addr", ADDR, 20'h0);
        chk("rst_data_z", Data, PULL);
        Reset = 1'b0;

        do_req(1'b1, 16'h0010, 16'hBEEF, lat, wl, ol);
        chk("wr_lat", lat, 4);
        chk("wr_we_low", wl, 2);
        chk("wr_oe_low", ol, 0);
        chk("wr_addr", ADDR, 20'h00010);

        do_req(1'b0, 16'h0010, 16'h4321, lat, wl, ol);
        chk("rd_lat", lat, 4);
        chk("rd_oe_low", ol, 2);
        chk("rd_we_low", wl, 0);
        chk("rd_data", rsp_rdata, 16'hBEEF);

        do_req(1'b0, 16'h0020, 16'h4321, lat, wl, ol);
        chk("rd2_data", rsp_rdata, 16'hC0DE);

        S = 16'h00F0;
        do_req(1'b0, IOA, 16'h0000, lat, wl, ol);
        chk("io_rd_lat", lat, 1);
        chk("io_rd_data", rsp_rdata, 16'h00F0);
        chk("io_strobes", {CE, OE, WE}, 3'b111);
        @(negedge Clk);
        S = 16'h1111;
        @(negedge Clk);
        chk("io_rd_hold", rsp_rdata, 16'h00F0);

        do_req(1'b1, IOA, 16'h1234, lat, wl, ol);
        chk("io_wr_lat", lat, 1);
        @(negedge Clk);
        chk("io_hex", hex_out, 16'h1234);

        base      = acc_t.size();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0030;
        req_wdata = 16'hA5C3;
        t = 0;
        while (acc_t.size() < base + 3 && t < 40) begin
            @(negedge Clk);
            t++;
        end
        req_valid = 1'b0;
        chk("b2b_count", acc_t.size() - base, 3);
        if (acc_t.size() >= base + 3) begin
            chk("b2b_gap1", acc_t[base + 1] - acc_t[base], 5);
            chk("b2b_gap2", acc_t[base + 2] - acc_t[base + 1], 5);
        end
        repeat (6) @(negedge Clk);

        do_req(1'b0, 16'h0030, 16'h0000, lat, wl, ol);
        chk("b2b_rd", rsp_rdata, 16'hA5C3);

        @(negedge Clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0040;
        req_wdata = 16'h7777;
        @(negedge Clk);
        req_valid = 1'b0;
        @(negedge Clk);
        chk("mid_we_low", WE, 0);
        #2 Reset = 1'b1;
        #1;
        chk("mid_rst_we", WE, 1);
        chk("mid_rst_ce", CE, 1);
        chk("mid_rst_data", Data, PULL);
        chk("mid_rst_valid", rsp_valid, 0);
        repeat (2) @(negedge Clk);
        chk("mid_rst_hex", hex_out, 16'h0);
        Reset = 1'b0;
        nv = 0;
        repeat (6) begin
            @(negedge Clk);
            if (rsp_valid) nv++;
        end
        chk("mid_rst_novalid", nv, 0);

        do_req(1'b0, 16'h0010, 16'h4321, lat, wl, ol);
        chk("post_rst_lat", lat, 4);
        chk("post_rst_data", rsp_rdata, 16'hBEEF);

        repeat (2) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_bus_ctrl.md
# sram_bus_ctrl

Memory/I-O access sequencer between the CPU datapath (MAR/MDR side) and the external asynchronous 16-bit SRAM on the shared tristate Data bus. It accepts one word read or write request at a time and generates the active-low CE/UB/LB/OE/WE strobes with a configurable number of wait states. It owns the bidirectional Data drive. It also decodes the memory-mapped I/O word (switch input / hex display register) so the datapath sees one uniform access interface.

## Interface
Parameters:
- WAIT_CYCLES, 2, cycles strobe is held active during an SRAM access; legal range 1..7
- IO_ADDR, 16'hFFFF, address decoded as the I/O word instead of SRAM

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high; one clock domain (Clk), no other clocks
- req_valid  in  1  request present
- req_ready  out  1  controller idle; request accepted when req_valid && req_ready at a rising edge
- req_we  in  1  1 = write, 0 = read
- req_addr  in  16  word address
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rdata  out  16  read data; valid when rsp_valid=1 for a read; holds the last read value otherwise
- S  in  16  switch input, returned on a read of IO_ADDR
- hex_out  out  16  I/O display register, written by a write to IO_ADDR
- CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active low
- ADDR  out  20  SRAM address = {4'b0, latched req_addr}
- Data  inout  16  SRAM data bus; driven only by this block during writes, otherwise high-Z

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE, IO.
- IDLE: req_ready=1, all strobes high, Data high-Z.
  - On accept, latch we, addr and wdata.
  - Next state is IO if addr==IO_ADDR, else SETUP.
- SETUP (1 cycle):
  - ADDR driven, CE=UB=LB=0.
  - Write: Data driven with wdata. OE=WE=1.
- ACCESS (WAIT_CYCLES cycles, down-counter loaded on accept):
  - Read: OE=0; Data sampled into rsp_rdata at the rising edge that ends the last ACCESS cycle.
  - Write: WE=0, Data driven.
- DONE (1 cycle):
  - rsp_valid=1, OE=WE=1, CE=0.
  - Write: Data still driven, giving one cycle of data hold after WE rises.
  - Then IDLE.
- IO (1 cycle): no SRAM strobes.
  - Read: rsp_rdata<=S.
  - Write: hex_out<=wdata.
  - rsp_valid=1 in this cycle; then IDLE.
- Data is never driven while OE=0.
- UB/LB always assert together (full-word only).
- req_ready=0 in every state but IDLE. Requests presented while busy are ignored, not queued.

## Timing
- Reset values:
  - Strobes: CE=UB=LB=OE=WE=1.
  - Outputs: ADDR=0, rsp_valid=0, rsp_rdata=0, hex_out=0, req_ready=1, Data=Z.
  - State: IDLE, counter=0.
- SRAM latency: accept edge → rsp_valid high for the cycle WAIT_CYCLES+2 cycles later.
- SRAM throughput: one access per WAIT_CYCLES+3 cycles, since req_ready returns in the cycle after DONE.
- I/O latency: rsp_valid in the cycle right after accept. Throughput: one access per 2 cycles.
- ADDR holds the latched address from SETUP through DONE, then keeps its value in IDLE (no glitch to 0).
- Reset asserted mid-access: all strobes go high and Data goes high-Z immediately (asynchronous), no rsp_valid is issued, and hex_out clears.
- req_valid held high continuously: a new request is accepted in every IDLE cycle. Back-to-back requests never overlap strobes.
- S is sampled only in the IO cycle. A change on S at other times has no effect.

## Structure
- Package sram_bus_pkg:
  - state enum (IDLE, SETUP, ACCESS, DONE, IO)
  - IO_ADDR default constant
  - strobe-bundle typedef (ce, ub, lb, oe, we)
- Sub-module bus_tristate: 16-bit tristate driver with inputs out_en and dout, inout Data, and output din. It is instantiated once. This is the only place Data is assigned.
- Top-level FSM, wait counter and request latches live in sram_bus_ctrl itself.

## Test plan
- Reset with Data pulled by a bench driver → all strobes 1, req_ready=1, Data not driven by the DUT, hex_out=0.
- Write 16'hBEEF to addr 16'h0010, WAIT_CYCLES=2:
  - WE low for exactly 2 cycles; ADDR=20'h00010.
  - Data=BEEF from SETUP through DONE.
  - rsp_valid at accept+4.
- Read of addr 16'h0010 from an SRAM model holding 16'hBEEF:
  - OE low for 2 cycles; Data never driven by the DUT.
  - rsp_rdata=BEEF with rsp_valid at accept+4.
- I/O path:
  - S=16'h00F0, read IO_ADDR → rsp_rdata=00F0 at accept+1, no strobe activity.
  - Write 16'h1234 to IO_ADDR → hex_out=1234.
- req_valid held high for 3 SRAM writes → accepts spaced exactly 5 cycles apart, with no overlapping strobes.
- Reset asserted during ACCESS of a write → WE/CE high and Data Z within the same cycle, no rsp_valid, and the next request after reset completes normally.
